// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 register file: register numbers, exception
// type encodings, ExcCode values and the Cause MTC0 write mask.
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;
    localparam logic [4:0] CP0_CONFIG  = 5'd16;

    localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
    localparam logic [31:0] EXC_RI        = 32'h0000_000a;
    localparam logic [31:0] EXC_OV        = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP      = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET      = 32'h0000_000e;

    localparam logic [4:0] EXCCODE_INT = 5'h00;
    localparam logic [4:0] EXCCODE_SYS = 5'h08;
    localparam logic [4:0] EXCCODE_RI  = 5'h0a;
    localparam logic [4:0] EXCCODE_OV  = 5'h0c;
    localparam logic [4:0] EXCCODE_TR  = 5'h0d;

    // Cause bits software may write: IV, WP, IP[9:8]
    localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

    localparam int STATUS_EXL = 1;
    localparam int CAUSE_BD   = 31;

    typedef enum logic [1:0] {
        EK_NONE,
        EK_TAKE,
        EK_RET
    } exc_kind_e;

    typedef struct packed {
        exc_kind_e  kind;
        logic [4:0] code;
    } exc_dec_t;

    // Map the MEM-stage exception type onto an action; unknown codes do nothing
    function automatic exc_dec_t cp0_decode_exc(input logic [31:0] et);
        exc_dec_t d;
        d.kind = EK_NONE;
        d.code = EXCCODE_INT;
        case (et)
            EXC_INTERRUPT: begin d.kind = EK_TAKE; d.code = EXCCODE_INT; end
            EXC_SYSCALL:   begin d.kind = EK_TAKE; d.code = EXCCODE_SYS; end
            EXC_RI:        begin d.kind = EK_TAKE; d.code = EXCCODE_RI;  end
            EXC_OV:        begin d.kind = EK_TAKE; d.code = EXCCODE_OV;  end
            EXC_TRAP:      begin d.kind = EK_TAKE; d.code = EXCCODE_TR;  end
            EXC_ERET:      begin d.kind = EK_RET; end
            default:       begin d.kind = EK_NONE; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cp0_reg_if.sv
// Bundle between the pipeline (write-back, MEM exception logic, MFC0) and CP0.
interface cp0_reg_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] cur_inst_addr_i;
    logic        in_delayslot_i;
    logic [31:0] rdata_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] config_o;
    logic [31:0] prid_o;
    logic        timer_int_o;

    modport master (
        output we_i, waddr_i, wdata_i, raddr_i, int_i,
               excepttype_i, cur_inst_addr_i, in_delayslot_i,
        input  rdata_o, count_o, compare_o, status_o, cause_o,
               epc_o, config_o, prid_o, timer_int_o
    );

    modport slave (
        input  we_i, waddr_i, wdata_i, raddr_i, int_i,
               excepttype_i, cur_inst_addr_i, in_delayslot_i,
        output rdata_o, count_o, compare_o, status_o, cause_o,
               epc_o, config_o, prid_o, timer_int_o
    );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running counter, compare register and the
// sticky timer interrupt that an MTC0 to Compare acknowledges.
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_timer_int
);
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_timer_int;

    // Count increments unless written; a Compare write clears the interrupt even if a match occurs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_compare   <= '0;
            r_timer_int <= 1'b0;
        end else begin
            r_count <= i_count_we ? i_wdata : r_count + 32'd1;
            if (i_compare_we) begin
                r_compare   <= i_wdata;
                r_timer_int <= 1'b0;
            end else if (r_compare != 32'd0 && r_count == r_compare) begin
                r_timer_int <= 1'b1;
            end
        end
    end

    assign o_count     = r_count;
    assign o_compare   = r_compare;
    assign o_timer_int = r_timer_int;
endmodule

// File: rtl/cp0_reg.sv
// CP0 system register file: MTC0 write port, MFC0 read port, exception/ERET
// state update. Optional same-cycle read bypass with CP0_RD_BYPASS_EN.
module cp0_reg
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h004C_0102,
    parameter logic [31:0] CONFIG_VAL = 32'h0000_8000,
    parameter logic [31:0] STATUS_RST = 32'h1000_0000
) (
    input  logic      clk,
    input  logic      reset,
    cp0_reg_if.slave  bus
);
    logic [31:0] r_status;
    logic [31:0] r_cause;
    logic [31:0] r_epc;

    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_timer_int;
    logic        w_count_we;
    logic        w_compare_we;
    exc_dec_t    w_exc;
    logic [31:0] w_cause_wr;
    logic [31:0] w_epc_exc;
    logic [31:0] w_rd_stored;

    assign w_count_we   = bus.we_i && (bus.waddr_i == CP0_COUNT);
    assign w_compare_we = bus.we_i && (bus.waddr_i == CP0_COMPARE);
    assign w_exc        = cp0_decode_exc(bus.excepttype_i);
    assign w_epc_exc    = bus.in_delayslot_i ? bus.cur_inst_addr_i - 32'd4 : bus.cur_inst_addr_i;

    cp0_timer u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_count_we   (w_count_we),
        .i_compare_we (w_compare_we),
        .i_wdata      (bus.wdata_i),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_timer_int  (w_timer_int)
    );

    // Cause after an MTC0: writable fields from wdata, everything else kept
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_cause_wr
            assign w_cause_wr[gi] = CAUSE_WMASK[gi] ? bus.wdata_i[gi] : r_cause[gi];
        end
    endgenerate

    // MTC0 updates first, then interrupt sampling and exception fields override
    always_ff @(posedge clk) begin
        if (reset) begin
            r_status <= STATUS_RST;
            r_cause  <= '0;
            r_epc    <= '0;
        end else begin
            if (bus.we_i && bus.waddr_i == CP0_STATUS) r_status <= bus.wdata_i;
            if (bus.we_i && bus.waddr_i == CP0_CAUSE)  r_cause  <= w_cause_wr;
            if (bus.we_i && bus.waddr_i == CP0_EPC)    r_epc    <= bus.wdata_i;
            r_cause[15:10] <= bus.int_i;
            case (w_exc.kind)
                EK_TAKE: begin
                    // Nested exception (EXL set) keeps the original return point
                    if (!r_status[STATUS_EXL]) begin
                        r_epc             <= w_epc_exc;
                        r_cause[CAUSE_BD] <= bus.in_delayslot_i;
                    end else begin
                        r_epc <= r_epc;
                    end
                    r_status[STATUS_EXL] <= 1'b1;
                    r_cause[6:2]         <= w_exc.code;
                end
                EK_RET: begin
                    r_status[STATUS_EXL] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // MFC0 read of the stored register values; unmapped numbers read zero
    always_comb begin
        w_rd_stored = '0;
        case (bus.raddr_i)
            CP0_COUNT:   w_rd_stored = w_count;
            CP0_COMPARE: w_rd_stored = w_compare;
            CP0_STATUS:  w_rd_stored = r_status;
            CP0_CAUSE:   w_rd_stored = r_cause;
            CP0_EPC:     w_rd_stored = r_epc;
            CP0_PRID:    w_rd_stored = PRID_VAL;
            CP0_CONFIG:  w_rd_stored = CONFIG_VAL;
            default:     w_rd_stored = '0;
        endcase
    end

`ifdef CP0_RD_BYPASS_EN
    logic [31:0] w_rd_bypass;

    // Forward the post-write value when MFC0 reads the register being written
    always_comb begin
        w_rd_bypass = w_rd_stored;
        if (bus.we_i && bus.waddr_i == bus.raddr_i) begin
            case (bus.waddr_i)
                CP0_COUNT, CP0_COMPARE, CP0_STATUS, CP0_EPC: w_rd_bypass = bus.wdata_i;
                CP0_CAUSE: w_rd_bypass = w_cause_wr;
                default:   w_rd_bypass = w_rd_stored;
            endcase
        end
    end

    assign bus.rdata_o = w_rd_bypass;
`else
    assign bus.rdata_o = w_rd_stored;
`endif

    assign bus.count_o     = w_count;
    assign bus.compare_o   = w_compare;
    assign bus.status_o    = r_status;
    assign bus.cause_o     = r_cause;
    assign bus.epc_o       = r_epc;
    assign bus.config_o    = CONFIG_VAL;
    assign bus.prid_o      = PRID_VAL;
    assign bus.timer_int_o = w_timer_int;
endmodule

// File: doc/cp0_reg.md
Name: cp0_reg

Overview:
- Coprocessor-0 system register file; consumer of the write-back stage CP0 write bundle (`wb_cp0_reg_we` / `wb_cp0_reg_write_addr` / `wb_cp0_reg_data`).
- Provides the MFC0 read port, the Count/Compare timer interrupt and exception/ERET state update (EPC, Status.EXL, Cause).
- Sits beside the GPR file at the end of the pipeline; its outputs feed the MEM-stage exception logic.

Parameters:
- PRID_VAL, 32'h004C_0102, constant PRId contents.
- CONFIG_VAL, 32'h0000_8000, constant Config contents (BE=1).
- STATUS_RST, 32'h1000_0000, Status reset value (CU0=1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- we_i  in  1  CP0 write enable (from wb_cp0_reg_we).
- waddr_i  in  5  write register number.
- wdata_i  in  32  write data.
- raddr_i  in  5  MFC0 read register number.
- int_i  in  6  external hardware interrupt lines.
- excepttype_i  in  32  exception type from MEM stage, one-hot-ish code (see Behaviour).
- cur_inst_addr_i  in  32  PC of the excepting instruction.
- in_delayslot_i  in  1  excepting instruction is in a delay slot.
- rdata_o  out  32  read data, combinational.
- count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  out  32 each  current register values.
- timer_int_o  out  1  timer interrupt, registered.

Behaviour:
- Register map:
  - Count=9, Compare=11, Status=12, Cause=13, EPC=14, PRId=15, Config=16.
  - Other addresses read 0; writes to them are ignored.
- Reset (reset=1 at a clk edge): Count, Compare, Cause, EPC = 0; Status = STATUS_RST; timer_int_o = 0.
- Count:
  - Increments by 1 every cycle, wrapping 32'hFFFF_FFFF -> 0.
  - An MTC0 to Count in the same cycle loads wdata_i; the write wins over the increment.
- Timer: timer_int_o sets (next edge) when Compare != 0 and Count == Compare. It holds until an MTC0 to Compare, which clears it. If set and clear occur in the same cycle, clear wins.
- Cause.IP[15:10] samples int_i every cycle. MTC0 writable fields:
  - Status: all 32 bits.
  - Cause: only IP[9:8], WP[22], IV[23].
  - Compare, EPC, Count: all bits.
  - PRId, Config: read-only; writes are ignored.
- Exceptions, applied at the clk edge where excepttype_i is nonzero:
  - 32'h1 interrupt, ExcCode 0x00.
  - 32'h8 syscall, 0x08.
  - 32'ha reserved instruction, 0x0a.
  - 32'hc overflow, 0x0c.
  - 32'hd trap, 0x0d.
  - 32'he ERET: Status.EXL <= 0, nothing else changes.
  - Any other nonzero value: no effect.
- Non-ERET exception:
  - If Status.EXL==0: EPC <= in_delayslot_i ? cur_inst_addr_i-4 : cur_inst_addr_i, and Cause.BD <= in_delayslot_i.
  - If Status.EXL==1: EPC and BD are unchanged.
  - Always: Status.EXL <= 1 and Cause.ExcCode[6:2] <= code.
- MTC0 and exception in the same cycle:
  - The exception wins for EPC, Status.EXL, Cause.BD and Cause.ExcCode.
  - All other written bits still take effect.
- Read: rdata_o = current register selected by raddr_i, zero-latency combinational, with no bypass unless the Optional Feature is enabled.

Optional Feature:
- Macro: CP0_RD_BYPASS_EN.
- Defined: when we_i=1 and waddr_i==raddr_i, rdata_o returns the post-write value of that register: wdata_i masked by the writable-field rules, merged with the unwritable bits. For PRId/Config the stored value is returned.
- Undefined: rdata_o shows the stored value only; the write is visible from the next cycle.

Decomposition:
- Package cp0_pkg holds:
  - Register-number constants (CP0_COUNT, CP0_COMPARE, CP0_STATUS, CP0_CAUSE, CP0_EPC, CP0_PRID, CP0_CONFIG).
  - Excepttype encodings, ExcCode values and the Cause writable mask 32'h00C0_0300.
- Sub-module cp0_timer owns Count, Compare and timer_int_o, with a write port and count/compare/timer_int outputs.

Test Plan:
- Reset 2 cycles, release -> status_o=32'h1000_0000, cause_o=0, count_o increments 0,1,2...; prid_o=32'h004C_0102.
- MTC0 Compare=32'd20 with Count reset to 0 -> timer_int_o rises at the edge after count_o==20. A later MTC0 Compare=50 clears it the next cycle.
- excepttype_i=32'h8, cur_inst_addr_i=32'h100, in_delayslot_i=1, EXL=0 -> epc_o=32'hFC, cause_o[31]=1, cause_o[6:2]=5'h08, status_o[1]=1. A second exception with addr 32'h200 leaves epc_o=32'hFC. excepttype_i=32'he then clears status_o[1].
- MTC0 Cause=32'hFFFF_FFFF with int_i=6'b000001 -> cause_o=32'h00C0_0700 (IP2 set from int_i).
- Same-cycle MTC0 EPC=32'h1234 and syscall at addr 32'h400 (EXL=0) -> epc_o=32'h400.
- With CP0_RD_BYPASS_EN: we_i=1, waddr_i=raddr_i=11, wdata_i=32'h55 -> rdata_o=32'h55 in that cycle. Without the macro, rdata_o shows the old value, then 32'h55 next cycle.
